// File: rtl/cnn_pkg.sv
// Shared CNN constants and the max-pool FSM encoding (also exported as the debug state output).
package cnn_pkg;

  localparam int unsigned CONV_IMAGE_SIZE  = 26;
  localparam int unsigned CONV_PIXEL_DEPTH = 20;
  localparam int unsigned POOL_IMAGE_SIZE  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } pool_state_e;

endpackage

// File: rtl/conv_max_pool.sv
// Streaming max-pool: raster-order signed pixels in, one signed maximum per square region out,
// emitted the cycle after the region's last pixel is accepted.
module conv_max_pool
  import cnn_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      in_valid,
  input  logic signed [CONV_PIXEL_DEPTH-1:0]        in_pixel,
  output logic                                      out_valid,
  output logic signed [CONV_PIXEL_DEPTH-1:0]        out_pixel,
  output logic [$clog2(POOL_IMAGE_SIZE**2)-1:0]     out_index,
  output logic                                      done,
  output logic [1:0]                                state
);

  localparam int unsigned REGION = CONV_IMAGE_SIZE / POOL_IMAGE_SIZE;
  localparam int unsigned CW     = $clog2(CONV_IMAGE_SIZE);
  localparam int unsigned RW     = (REGION > 1) ? $clog2(REGION) : 1;
  localparam int unsigned BW     = (POOL_IMAGE_SIZE > 1) ? $clog2(POOL_IMAGE_SIZE) : 1;
  localparam int unsigned IW     = $clog2(POOL_IMAGE_SIZE**2);

  if (CONV_IMAGE_SIZE % POOL_IMAGE_SIZE != 0) begin : g_size_check
    $error("CONV_IMAGE_SIZE must be divisible by POOL_IMAGE_SIZE");
  end

  pool_state_e state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  // Position within the current region and current column band, kept alongside row/col
  // so no divider/modulo is needed.
  logic [RW-1:0] rsub_q, rsub_d, csub_q, csub_d;
  logic [BW-1:0] band_q, band_d;
  logic signed [CONV_PIXEL_DEPTH-1:0] max_q [POOL_IMAGE_SIZE];
  logic signed [CONV_PIXEL_DEPTH-1:0] max_d [POOL_IMAGE_SIZE];
  logic                               out_valid_q, out_valid_d;
  logic signed [CONV_PIXEL_DEPTH-1:0] out_pixel_q, out_pixel_d;
  logic [IW-1:0]                      out_index_q, out_index_d;
  logic                               done_q, done_d;
  logic signed [CONV_PIXEL_DEPTH-1:0] cur_max, new_max;
  logic                               region_first, region_last, frame_last;

  always_comb begin
    cur_max      = max_q[band_q];
    region_first = (rsub_q == '0) && (csub_q == '0);
    region_last  = (rsub_q == RW'(REGION - 1)) && (csub_q == RW'(REGION - 1));
    frame_last   = (row_q == CW'(CONV_IMAGE_SIZE - 1)) && (col_q == CW'(CONV_IMAGE_SIZE - 1));
    // Ties keep the stored value; the first pixel of a region loads unconditionally.
    new_max      = (region_first || (in_pixel > cur_max)) ? in_pixel : cur_max;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    rsub_d      = rsub_q;
    csub_d      = csub_q;
    band_d      = band_q;
    max_d       = max_q;
    out_valid_d = 1'b0;
    out_pixel_d = out_pixel_q;
    out_index_d = out_index_q;
    done_d      = done_q;

    if (out_valid_q) out_index_d = out_index_q + IW'(1);

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          done_d      = 1'b0;
          row_d       = '0;
          col_d       = '0;
          rsub_d      = '0;
          csub_d      = '0;
          band_d      = '0;
          out_index_d = '0;
        end
      end
      StRun: begin
        if (in_valid) begin
          max_d[band_q] = new_max;
          if (region_last) begin
            out_valid_d = 1'b1;
            out_pixel_d = new_max;
          end

          if (csub_q == RW'(REGION - 1)) begin
            csub_d = '0;
            band_d = (band_q == BW'(POOL_IMAGE_SIZE - 1)) ? '0 : band_q + BW'(1);
          end else begin
            csub_d = csub_q + RW'(1);
          end

          if (col_q == CW'(CONV_IMAGE_SIZE - 1)) begin
            col_d  = '0;
            row_d  = row_q + CW'(1);
            rsub_d = (rsub_q == RW'(REGION - 1)) ? '0 : rsub_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end

          if (frame_last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      rsub_q      <= '0;
      csub_q      <= '0;
      band_q      <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < POOL_IMAGE_SIZE; i++) max_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rsub_q      <= rsub_d;
      csub_q      <= csub_d;
      band_q      <= band_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
      max_q       <= max_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_index = out_index_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_conv_max_pool.sv
// Scoreboard bench for conv_max_pool: stimulus pushes hand-computed pooled results, a negedge
// monitor pops and compares on every out_valid.
module tb_conv_max_pool;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic signed [19:0] in_pixel;
  logic               out_valid;
  logic signed [19:0] out_pixel;
  logic [1:0]         out_index;
  logic               done;
  logic [1:0]         state;

  conv_max_pool dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_index (out_index),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int val;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   nvalid = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      nvalid++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out_valid: got pixel %0d index %0d, expected none (t=%0t)",
                 out_pixel, out_index, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_index", int'(out_index), e.idx);
        check("out_pixel", int'(out_pixel), e.val);
        check("done_with_out_valid", int'(done), e.last);
      end
    end
  end

  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      0: return r * 26 + c;
      1: return (r == 20 && c == 3) ? -1 : ((r == 0 && c == 25) ? -2 : -5);
      default: return 7;
    endcase
  endfunction

  task automatic push_exp(input int v0, input int v1, input int v2, input int v3, input int n);
    int vals[4];
    vals = '{v0, v1, v2, v3};
    for (int i = 0; i < n; i++) exp_q.push_back('{idx: i, val: vals[i], last: (i == 3) ? 1 : 0});
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("state_after_start", int'(state), 1);
    check("done_after_start", int'(done), 0);
  endtask

  task automatic send_frame(input int kind, input bit gapped, input int abort_at,
                            input int start_mid);
    int n = 0;
    for (int r = 0; r < 26; r++) begin
      for (int c = 0; c < 26; c++) begin
        if (abort_at >= 0 && n == abort_at) return;
        in_pixel = 20'(pix(kind, r, c));
        in_valid = 1'b1;
        start    = (n == start_mid);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
        in_pixel = 20'(12345);
        n++;
        if (gapped) begin
          @(posedge clk); #1;
          if (n % 37 == 0) repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
        end
      end
    end
  endtask

  task automatic drain_and_check_done();
    @(negedge clk);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("out_valid_count", nvalid, 4);
    check("state_done", int'(state), 2);
    check("done_level", int'(done), 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pixel", int'(out_pixel), 0);
    check("reset_out_index", int'(out_index), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b1;

    // in_valid while idle is ignored
    @(posedge clk); #1;
    in_valid = 1'b1; in_pixel = 20'(999);
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("idle_ignores_in_valid", int'(state), 0);

    // Ramp frame
    do_start();
    nvalid = 0;
    push_exp(324, 337, 662, 675, 4);
    send_frame(0, 1'b0, -1, -1);
    drain_and_check_done();

    // in_valid while done is ignored
    nvalid = 0;
    in_valid = 1'b1; in_pixel = 20'(50000);
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(negedge clk);
    check("done_ignores_in_valid", nvalid, 0);
    check("done_state_held", int'(state), 2);

    // Negative values, started from DONE
    do_start();
    nvalid = 0;
    push_exp(-5, -2, -1, -5, 4);
    send_frame(1, 1'b0, -1, -1);
    drain_and_check_done();

    // Gapped ramp with a start pulse mid-frame
    do_start();
    nvalid = 0;
    push_exp(324, 337, 662, 675, 4);
    send_frame(0, 1'b1, -1, 100);
    drain_and_check_done();

    // Reset after 400 pixels: regions 0 and 1 have already completed
    do_start();
    nvalid = 0;
    push_exp(324, 337, 0, 0, 2);
    send_frame(0, 1'b0, 400, -1);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_state", int'(state), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_pixel", int'(out_pixel), 0);
    check("midreset_out_index", int'(out_index), 0);
    check("midreset_done", int'(done), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_queue_empty", exp_q.size(), 0);
    check("midreset_valid_count", nvalid, 2);
    #1;

    // Ramp after reset
    do_start();
    nvalid = 0;
    push_exp(324, 337, 662, 675, 4);
    send_frame(0, 1'b0, -1, -1);
    drain_and_check_done();

    // Back-to-back constant frame, index restarts at 0
    do_start();
    nvalid = 0;
    push_exp(7, 7, 7, 7, 4);
    send_frame(2, 1'b0, -1, -1);
    drain_and_check_done();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
